// File: rtl/instr_mem_fetch.sv
// Byte-addressed little-endian instruction store with a registered valid/ready
// fetch port and a byte-wide program-load port; faulting fetches return a NOP.
module instr_mem_fetch #(
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter logic [31:0] NOP_INST    = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  prog_en,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [7:0]            prog_data,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_inst,
    output logic [ADDR_WIDTH-1:0] resp_addr,
    output logic [1:0]            resp_fault
);

    localparam int unsigned           IDX_W     = $clog2(DEPTH_BYTES);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH_BYTES - 4);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(DEPTH_BYTES);

    typedef enum logic {S_RUN, S_LOAD} state_e;

    state_e                  state_q, state_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [31:0]             resp_inst_q, resp_inst_d;
    logic [ADDR_WIDTH-1:0]   resp_addr_q, resp_addr_d;
    logic [1:0]              resp_fault_q, resp_fault_d;

    logic [7:0]              mem [DEPTH_BYTES];
    logic                    fetch_acc;
    logic [1:0]              fault_w;
    logic [IDX_W-1:0]        rd_idx;
    logic [31:0]             rd_word;
    logic                    wr_en;
    logic [IDX_W-1:0]        wr_idx;

    assign req_ready = (state_q == S_RUN) && !prog_en && (!resp_valid_q || resp_ready);
    assign fetch_acc = req_valid && req_ready;

    // Misalignment wins over range; range compare is full-width so high PCs never wrap in.
    always_comb begin
        fault_w = 2'b00;
        if (req_addr[1:0] != 2'b00) begin
            fault_w = 2'b01;
        end else if (req_addr > LAST_WORD) begin
            fault_w = 2'b10;
        end
    end

    // Index is parked at 0 on a fault so the +3 byte never leaves the array.
    assign rd_idx  = (fault_w == 2'b00) ? req_addr[IDX_W-1:0] : '0;
    assign rd_word = {mem[rd_idx + IDX_W'(3)], mem[rd_idx + IDX_W'(2)],
                      mem[rd_idx + IDX_W'(1)], mem[rd_idx]};

    assign wr_en  = (state_q == S_LOAD) && prog_en && prog_we && (prog_addr < DEPTH_A);
    assign wr_idx = prog_addr[IDX_W-1:0];

    always_comb begin
        state_d = prog_en ? S_LOAD : S_RUN;
    end

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_inst_d  = resp_inst_q;
        resp_addr_d  = resp_addr_q;
        resp_fault_d = resp_fault_q;
        if (fetch_acc) begin
            resp_valid_d = 1'b1;
            resp_addr_d  = req_addr;
            resp_fault_d = fault_w;
            resp_inst_d  = (fault_w != 2'b00) ? NOP_INST : rd_word;
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_RUN;
            resp_valid_q <= 1'b0;
            resp_inst_q  <= '0;
            resp_addr_q  <= '0;
            resp_fault_q <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_inst_q  <= resp_inst_d;
            resp_addr_q  <= resp_addr_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    // Storage deliberately has no reset so a loaded program survives a core reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= prog_data;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_inst  = resp_inst_q;
    assign resp_addr  = resp_addr_q;
    assign resp_fault = resp_fault_q;

endmodule
